// File: rtl/wb_copy_master.sv
// Wishbone classic block copier: one read and then one write per word, with a single idle bus cycle after each.
// Per word 2N+2 cycles (N = ack wait). A slave that holds ack low for TIMEOUT cycles aborts the command with err.
module wb_copy_master #(
  parameter int LEN_BITS = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_BITS-1:0] len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LEN_BITS-1:0] words_done,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_src;
  logic [31:0]         r_dst;
  logic [31:0]         r_data;
  logic [LEN_BITS-1:0] r_rem;
  logic [LEN_BITS-1:0] r_words;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;

  logic w_req;
  logic w_ack;
  logic w_expire;

  assign w_req    = (r_state == S_RD) || (r_state == S_WR);
  assign w_ack    = w_req && wbm_ack_i;
  // An ack in the final allowed cycle takes priority over the abort.
  assign w_expire = w_req && !wbm_ack_i && (r_wait == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'h0;
    wbm_adr_o  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = r_src;
        if (w_ack) begin
          w_next = S_RD_GAP;
        end else if (w_expire) begin
          w_next = S_FIN;
        end
      end
      S_RD_GAP: begin
        busy   = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = r_dst;
        if (w_ack) begin
          w_next = S_WR_GAP;
        end else if (w_expire) begin
          w_next = S_FIN;
        end
      end
      S_WR_GAP: begin
        busy = 1'b1;
        // The remaining count was already decremented on the write ack.
        w_next = (r_rem == '0) ? S_FIN : S_RD;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_data  <= 32'h0;
      r_rem   <= '0;
      r_words <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (start) begin
            r_src   <= src_addr & 32'hFFFF_FFFC;
            r_dst   <= dst_addr & 32'hFFFF_FFFC;
            r_rem   <= len;
            r_words <= '0;
            r_err   <= 1'b0;
          end
        end
        S_RD, S_WR: begin
          if (w_ack) begin
            r_wait <= '0;
            if (r_state == S_RD) begin
              r_data <= wbm_dat_i;
              r_src  <= r_src + 32'd4;
            end else begin
              r_dst   <= r_dst + 32'd4;
              r_words <= r_words + LEN_BITS'(1);
              r_rem   <= r_rem - LEN_BITS'(1);
            end
          end else if (w_expire) begin
            r_wait <= '0;
            r_err  <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
          r_wait <= '0;
        end
      endcase
    end
  end

  assign err        = r_err;
  assign words_done = r_words;
  assign wbm_dat_o  = r_data;

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master with a behavioural Wishbone slave whose ack wait and ack budget are programmable.
module tb_wb_copy_master;
  localparam int LB = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LB-1:0] len;
  logic          busy;
  logic          done;
  logic          err;
  logic [LB-1:0] words_done;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [31:0]   wbm_dat_i;
  logic          wbm_ack_i;

  always #5 clk = ~clk;

  wb_copy_master #(.LEN_BITS(LB), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .words_done(words_done), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  // Slave: read data from rom, ack on the Nth stb cycle while the ack budget lasts.
  logic [31:0] rom [256];
  int s_wait_n  = 1;
  int s_ack_lim = 1000000;
  int s_cnt     = 0;
  int s_acks    = 0;
  int stb_cycles = 0;
  int viol      = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_t;
  tx_t txq[$];

  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (s_cnt == s_wait_n - 1) && (s_acks < s_ack_lim);
  assign wbm_dat_i = rom[wbm_adr_o[9:2]];

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_ack_i) begin
      txq.push_back('{we: wbm_we_o, adr: wbm_adr_o, dat: wbm_dat_o});
      s_acks <= s_acks + 1;
    end
    if (wbm_cyc_o && !wbm_ack_i) s_cnt <= s_cnt + 1;
    else s_cnt <= 0;
    if (wbm_stb_o) stb_cycles <= stb_cycles + 1;
    if ((wbm_stb_o != wbm_cyc_o) || (wbm_sel_o != (wbm_stb_o ? 4'hF : 4'h0)) ||
        (wbm_adr_o[1:0] != 2'b00))
      viol <= viol + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int k, input int i);
    return 32'((i + 1) * 32'h11) + (32'(k) << 24);
  endfunction

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          wait_n;
    int          ack_lim;
    int          exp_words;
    logic        exp_err;
    int          exp_delta;
    int          exp_stb;
    int          exp_tx;
  } vec_t;

  vec_t vt[7];

  // Runs one command; inj > 0 pulses a competing start at that cycle after the accepting edge.
  task automatic run_cmd(input vec_t v, input int k, input int inj);
    int          c;
    int          tx_base;
    int          stb_base;
    logic        ok;
    logic [31:0] a;
    tx_t         t;
    s_wait_n  = v.wait_n;
    s_ack_lim = s_acks + v.ack_lim;
    tx_base   = txq.size();
    stb_base  = stb_cycles;
    for (int i = 0; i < v.len; i++) begin
      a = v.src + 32'(4 * i);
      rom[a[9:2]] = pat(k, i);
    end
    @(negedge clk);
    src_addr = v.src | 32'h3;
    dst_addr = v.dst | 32'h2;
    len      = LB'(v.len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    src_addr = 32'hDEAD_BEE0;
    dst_addr = 32'hCAFE_0000;
    len      = LB'(7);
    c = 1;
    check($sformatf("v%0d busy_after_start", k), busy, (v.len != 0));
    check($sformatf("v%0d err_cleared", k), err, 0);
    while (!done && c < 3000) begin
      if (c == inj) begin
        src_addr = 32'h3800_0300;
        dst_addr = 32'h3800_0380;
        len      = LB'(5);
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check($sformatf("v%0d done_latency", k), c, v.exp_delta);
    check($sformatf("v%0d words_done", k), words_done, v.exp_words);
    check($sformatf("v%0d err", k), err, v.exp_err);
    check($sformatf("v%0d busy_in_fin", k), busy, 0);
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", k), done, 0);
    check($sformatf("v%0d err_held", k), err, v.exp_err);
    check($sformatf("v%0d stb_cycles", k), stb_cycles - stb_base, v.exp_stb);
    check($sformatf("v%0d transfers", k), txq.size() - tx_base, v.exp_tx);
    ok = 1'b1;
    for (int j = 0; j < v.exp_tx && (tx_base + j) < txq.size(); j++) begin
      t = txq[tx_base + j];
      if (t.we != 1'(j % 2)) ok = 1'b0;
      if (t.adr != (((j % 2) != 0) ? v.dst : v.src) + 32'(4 * (j / 2))) ok = 1'b0;
      if (t.we && t.dat != pat(k, j / 2)) ok = 1'b0;
    end
    check($sformatf("v%0d bus_sequence", k), ok, 1);
  endtask

  initial begin
    int   tx_base;
    int   stb_base;
    int   dcount;
    logic found;
    vec_t vb;

    //        src           dst           len wait ack_lim words err delta stb  tx
    vt[0] = '{32'h3800_0000, 32'h3800_0100, 3, 11, 1000, 3, 1'b0, 73, 66, 6};
    vt[1] = '{32'h3800_0040, 32'h3800_0140, 0, 11, 1000, 0, 1'b0,  1,  0, 0};
    vt[2] = '{32'h3800_0080, 32'h3800_0180, 2,  1,    0, 0, 1'b1, 17, 16, 0};
    vt[3] = '{32'h3800_0020, 32'h3800_0120, 2,  1, 1000, 2, 1'b0,  9,  4, 4};
    vt[4] = '{32'h3800_0060, 32'h3800_01C0, 2, 16, 1000, 2, 1'b0, 69, 64, 4};
    vt[5] = '{32'hFFFF_FFF8, 32'h3800_0200, 3,  2, 1000, 3, 1'b0, 19, 12, 6};
    vt[6] = '{32'h3800_0000, 32'h3800_0100, 3,  2,    3, 1, 1'b1, 26, 22, 3};

    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rst = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst cyc", wbm_cyc_o, 0);
    check("rst stb", wbm_stb_o, 0);
    check("rst we", wbm_we_o, 0);
    check("rst sel", wbm_sel_o, 0);
    check("rst adr", wbm_adr_o, 0);
    check("rst dat_o", wbm_dat_o, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst words_done", words_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    for (int k = 0; k < 7; k++) run_cmd(vt[k], k, 0);

    // Competing start while busy must be dropped, not queued.
    vb = '{32'h3800_0000, 32'h3800_0100, 2, 3, 1000, 2, 1'b0, 17, 12, 4};
    run_cmd(vb, 7, 5);
    stb_base = stb_cycles;
    repeat (6) @(negedge clk);
    check("busy_start no_queue_stb", stb_cycles - stb_base, 0);
    check("busy_start idle", busy, 0);

    // Reset while the second word is being written.
    s_wait_n  = 4;
    s_ack_lim = s_acks + 1000;
    for (int i = 0; i < 3; i++) rom[i] = pat(8, i);
    @(negedge clk);
    src_addr = 32'h3800_0000; dst_addr = 32'h3800_0100; len = LB'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (wbm_we_o && words_done == LB'(1)) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid reached_word2_write", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid cyc", wbm_cyc_o, 0);
    check("rst_mid stb", wbm_stb_o, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid words_done", words_done, 0);
    check("rst_mid done", done, 0);
    dcount = 0;
    tx_base = txq.size();
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("rst_mid no_done_after", dcount, 0);
    check("rst_mid no_transfers_after", txq.size() - tx_base, 0);

    run_cmd(vt[0], 0, 0);

    @(negedge clk);
    check("bus_invariants", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
